sparc_exu_alu_pipe: RTL and testbench
=====================================

Name: sparc_exu_alu_pipe

Overview:
Parametrised, pipelined successor of the EXU integer ALU datapath. Computes add/sub, logic, move and rs3-pass results at configurable width, and produces full-width and half-width condition codes plus a VA-range check. Uses a valid/ready handshake with configurable register depth, so it can feed a stallable bypass or LSU stage.

Parameters:
WIDTH, 64, datapath width in bits; even, >= 8.
VA_W, 48, implemented VA bits; range check covers result[WIDTH-1:VA_W-1]; VA_W < WIDTH.
STAGES, 2, pipeline register depth; legal values 1..4.

Ports:
rclk  in  1  clock
arst_l  in  1  asynchronous active-low reset
in_vld  in  1  operation valid
in_rdy  out  1  block can accept operation this cycle
op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOVE(rs2), 6 RS3, 7 reserved (treated as ADD)
inv  in  1  invert rs2 for logic ops (ANDN/ORN/XNOR)
cin  in  1  carry-in for ADD (ADDC)
rs1  in  WIDTH  operand 1
rs2  in  WIDTH  operand 2
rs3  in  WIDTH  operand 3 (store data pass)
tag  in  5  destination tag, carried alongside result
out_vld  out  1  result valid
out_rdy  in  1  consumer accepts result
result  out  WIDTH  ALU result
out_tag  out  5  tag of result
cc_full  out  4  {N,Z,V,C} over WIDTH bits
cc_half  out  4  {N,Z,V,C} over low WIDTH/2 bits
va_invalid  out  1  result[WIDTH-1:VA_W-1] neither all-0 nor all-1

Behaviour:
- Arithmetic: ADD = rs1+rs2+cin; SUB = rs1+~rs2+1 (cin ignored). Result is modulo 2^WIDTH.
- C for ADD = carry out; C for SUB = borrow (inverted carry out). Half C is taken at bit WIDTH/2 with the same convention.
- V = signed overflow at the respective MSB. Logic/MOVE/RS3 ops: V=C=0, N=MSB, Z=all-zero of the respective span.
- Logic ops: rs2 is replaced by ~rs2 when inv=1. MOVE returns rs2 (inv ignored). RS3 returns rs3.
- Combinational compute feeds stage 0. Results travel through STAGES registers. Latency from accept to out_vld = STAGES cycles when unstalled.
- Each stage holds a valid bit. Stage k loads when it is empty or stage k+1 loads (last stage: out_rdy). in_rdy = stage-0 load condition.
- in_rdy has a combinational path from out_rdy. Full throughput is 1 op/cycle.
- Accept = in_vld & in_rdy. Transfer = out_vld & out_rdy.
- While out_vld=1 and out_rdy=0, result, out_tag, cc_* and va_invalid stay stable. The pipe fills to at most STAGES entries, then in_rdy=0.
- Simultaneous accept and transfer at full occupancy is permitted with no bubble.
- Data registers are non-reset. Valid bits reset to 0 asynchronously on arst_l low, including mid-operation; in-flight ops are discarded.
- Reset values: out_vld=0, in_rdy=1 after reset release. Data outputs are don't-care while out_vld=0, but must not be X-propagated into out_vld.
- va_invalid is computed from result in the same stage as result.
- op=7 behaves exactly as ADD.

Test Plan:
- WIDTH=64, STAGES=2: ADD rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1, cin=0, out_rdy=1 -> after 2 cycles result=0, cc_full={0,1,0,1}, cc_half={0,1,0,1}, va_invalid=0.
- SUB rs1=0x7FFF_FFFF_FFFF_FFFF, rs2=0xFFFF_FFFF_FFFF_FFFF -> result=0x8000_0000_0000_0000, cc_full N=1 V=1 C=1, va_invalid=1.
- XOR with inv=1, rs1=rs2=0x1234 -> result=0xFFFF_FFFF_FFFF_FFFF, cc_full={1,0,0,0}; MOVE inv=1 rs2=5 -> 5.
- Backpressure: 4 ops with tags 1..4 back-to-back, out_rdy=0 -> in_rdy drops after 2 accepts. Raise out_rdy -> tags emerge 1,2,3,4 in order, results stable while stalled, no loss or duplication.
- arst_l pulsed low mid-stream with 2 ops in flight -> out_vld=0 immediately, in_rdy=1 after release, and the next op emerges with its own tag only.
- WIDTH=32, VA_W=24, STAGES=1: ADD 0x0080_0000+0 -> va_invalid=1, latency 1. ADD 0xFF80_0000+0 -> va_invalid=0. cc_half uses bit 15/16.

Source files
------------

// File: rtl/sparc_exu_alu_pipe.sv
// sparc_exu_alu_pipe: pipelined integer ALU for the EXU.
// Computes ADD/ADDC/SUB, AND/OR/XOR (with optional rs2 inversion), MOVE and
// rs3 pass-through. It also produces {N,Z,V,C} over the full and low-half
// width, plus a VA-range check. The result then moves through STAGES
// valid/ready pipeline registers. A stalled stage holds its contents.
//
// Ports:
//   rclk, arst_l        clock, asynchronous active-low reset (valid bits only)
//   in_vld / in_rdy     operation handshake; in_rdy is combinational from out_rdy
//   op, inv, cin        opcode, rs2 inversion for logic ops, carry-in for ADD
//   rs1, rs2, rs3, tag  operands and destination tag
//   out_vld / out_rdy   result handshake
//   result, out_tag     result and its tag
//   cc_full, cc_half    {N,Z,V,C} over WIDTH bits and over the low WIDTH/2 bits
//   va_invalid          result[WIDTH-1:VA_W-1] is neither all-0 nor all-1
module sparc_exu_alu_pipe #(
  parameter int WIDTH  = 64,
  parameter int VA_W   = 48,
  parameter int STAGES = 2
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [2:0]       op,
  input  logic             inv,
  input  logic             cin,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] rs3,
  input  logic [4:0]       tag,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       out_tag,
  output logic [3:0]       cc_full,
  output logic [3:0]       cc_half,
  output logic             va_invalid
);
  localparam int H       = WIDTH / 2;
  localparam int VA_SPAN = WIDTH - VA_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [4:0]       tag;
    logic [3:0]       ccf;
    logic [3:0]       cch;
    logic             va;
  } pld_t;

  // ---------------------------------------------------------------- compute
  logic               is_sub, is_arith, c_in, c_half, v_full, v_half;
  logic [WIDTH-1:0]   b_arith, b_log, res;
  logic [WIDTH:0]     sum;
  logic [VA_SPAN-1:0] va_bits;
  pld_t               pld_d;

  always_comb begin
    is_sub   = (op == 3'd1);
    // Reserved opcode 7 aliases ADD.
    is_arith = (op == 3'd0) || is_sub || (op == 3'd7);
    // SUB is done as rs1 + ~rs2 + 1, so one adder serves both.
    b_arith  = is_sub ? ~rs2 : rs2;
    c_in     = is_sub | cin;
    sum      = {1'b0, rs1} + {1'b0, b_arith} + {{WIDTH{1'b0}}, c_in};
    // Carry out of the low half equals the carry into bit H of the full sum.
    c_half   = sum[H] ^ rs1[H] ^ b_arith[H];
    v_full   = (rs1[WIDTH-1] == b_arith[WIDTH-1]) && (sum[WIDTH-1] != rs1[WIDTH-1]);
    v_half   = (rs1[H-1] == b_arith[H-1]) && (sum[H-1] != rs1[H-1]);
    b_log    = inv ? ~rs2 : rs2;
    case (op)
      3'd2:    res = rs1 & b_log;
      3'd3:    res = rs1 | b_log;
      3'd4:    res = rs1 ^ b_log;
      3'd5:    res = rs2;
      3'd6:    res = rs3;
      default: res = sum[WIDTH-1:0];
    endcase
    va_bits   = res[WIDTH-1:VA_W-1];
    pld_d.res = res;
    pld_d.tag = tag;
    // The adder carry becomes a borrow for SUB, so it is inverted there.
    pld_d.ccf = {res[WIDTH-1], ~|res, is_arith & v_full,
                 is_arith & (sum[WIDTH] ^ is_sub)};
    pld_d.cch = {res[H-1], ~|res[H-1:0], is_arith & v_half,
                 is_arith & (c_half ^ is_sub)};
    pld_d.va  = (|va_bits) & ~(&va_bits);
  end

  // --------------------------------------------------------------- pipeline
  // Stage STAGES-1 is the output stage.
  logic [STAGES-1:0] vld_pipe, vld_nxt, ld, msk;
  pld_t              pipe_q [STAGES];
  pld_t              pipe_d [STAGES];

  // A stage loads when out_rdy is high or when it, or any stage downstream of
  // it, is empty. The bubble then collapses forward in the same cycle.
  always_comb begin
    ld  = '0;
    msk = '0;
    for (int k = 0; k < STAGES; k++) begin
      msk = '0;
      for (int j = 0; j < k; j++) msk[j] = 1'b1;
      ld[k] = out_rdy | ~&(vld_pipe | msk);
    end
  end

  always_comb begin
    vld_nxt    = '0;
    vld_nxt[0] = in_vld;
    pipe_d[0]  = pld_d;
    for (int k = 1; k < STAGES; k++) begin
      vld_nxt[k] = vld_pipe[k-1];
      pipe_d[k]  = pipe_q[k-1];
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      vld_pipe <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (ld[k]) vld_pipe[k] <= vld_nxt[k];
    end
  end

  // Payload registers have no reset. They are qualified by vld_pipe only.
  always_ff @(posedge rclk) begin
    for (int k = 0; k < STAGES; k++)
      if (ld[k]) pipe_q[k] <= pipe_d[k];
  end

  assign in_rdy     = ld[0];
  assign out_vld    = vld_pipe[STAGES-1];
  assign result     = pipe_q[STAGES-1].res;
  assign out_tag    = pipe_q[STAGES-1].tag;
  assign cc_full    = pipe_q[STAGES-1].ccf;
  assign cc_half    = pipe_q[STAGES-1].cch;
  assign va_invalid = pipe_q[STAGES-1].va;

endmodule

// File: tb/tb_sparc_exu_alu_pipe.sv
// Bench for sparc_exu_alu_pipe. There are two instances: A uses the defaults
// 64/48/2 and B uses 32/24/1. The reference model computes results and flags
// with wide signed/unsigned integer arithmetic. Queues track the accept and
// transfer order.
module tb_sparc_exu_alu_pipe;
  localparam int AW = 64, AVA = 48, AST = 2;
  localparam int BW = 32, BVA = 24, BST = 1;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;
  logic arst_l;

  logic          a_in_vld, a_in_rdy, a_inv, a_cin, a_out_vld, a_out_rdy, a_va;
  logic [2:0]    a_op;
  logic [AW-1:0] a_rs1, a_rs2, a_rs3, a_result;
  logic [4:0]    a_tag, a_out_tag;
  logic [3:0]    a_ccf, a_cch;

  logic          b_in_vld, b_in_rdy, b_inv, b_cin, b_out_vld, b_out_rdy, b_va;
  logic [2:0]    b_op;
  logic [BW-1:0] b_rs1, b_rs2, b_rs3, b_result;
  logic [4:0]    b_tag, b_out_tag;
  logic [3:0]    b_ccf, b_cch;

  sparc_exu_alu_pipe #(.WIDTH(AW), .VA_W(AVA), .STAGES(AST)) dut_a (
    .rclk(rclk), .arst_l(arst_l), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
    .op(a_op), .inv(a_inv), .cin(a_cin), .rs1(a_rs1), .rs2(a_rs2), .rs3(a_rs3),
    .tag(a_tag), .out_vld(a_out_vld), .out_rdy(a_out_rdy), .result(a_result),
    .out_tag(a_out_tag), .cc_full(a_ccf), .cc_half(a_cch), .va_invalid(a_va));

  sparc_exu_alu_pipe #(.WIDTH(BW), .VA_W(BVA), .STAGES(BST)) dut_b (
    .rclk(rclk), .arst_l(arst_l), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
    .op(b_op), .inv(b_inv), .cin(b_cin), .rs1(b_rs1), .rs2(b_rs2), .rs3(b_rs3),
    .tag(b_tag), .out_vld(b_out_vld), .out_rdy(b_out_rdy), .result(b_result),
    .out_tag(b_out_tag), .cc_full(b_ccf), .cc_half(b_cch), .va_invalid(b_va));

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    logic [3:0]  ccf;
    logic [3:0]  cch;
    logic        va;
  } rec_t;

  rec_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------------------------------------------------- reference model
  function automatic logic signed [67:0] sx(input logic [63:0] v, input int n);
    logic signed [67:0] t;
    t = '0;
    for (int i = 0; i < n; i++) t[i] = v[i];
    if (v[n-1]) t = t - (68'sd1 <<< n);
    return t;
  endfunction

  function automatic logic [67:0] ux(input logic [63:0] v, input int n);
    logic [67:0] t;
    t = '0;
    for (int i = 0; i < n; i++) t[i] = v[i];
    return t;
  endfunction

  function automatic rec_t model(input int w, input int vaw, input logic [2:0] op,
                                 input logic inv, input logic cin, input logic [63:0] r1,
                                 input logic [63:0] r2, input logic [63:0] r3,
                                 input logic [4:0] tg);
    rec_t m;
    int h;
    logic [63:0] b, res;
    logic signed [67:0] st, sh, lo, hi, loh, hih;
    logic [67:0] uf, uh;
    logic c, v, ch, vh, zh, all0, all1;
    h = w / 2;
    c = 0; v = 0; ch = 0; vh = 0;
    st = '0; sh = '0; uf = '0; uh = '0;
    b   = inv ? ~r2 : r2;
    lo  = -(68'sd1 <<< (w - 1)); hi  = (68'sd1 <<< (w - 1)) - 68'sd1;
    loh = -(68'sd1 <<< (h - 1)); hih = (68'sd1 <<< (h - 1)) - 68'sd1;
    case (op)
      3'd1: begin
        st  = sx(r1, w) - sx(r2, w);
        sh  = sx(r1, h) - sx(r2, h);
        res = st[63:0];
        c   = ux(r1, w) < ux(r2, w);
        ch  = ux(r1, h) < ux(r2, h);
        v   = (st < lo) || (st > hi);
        vh  = (sh < loh) || (sh > hih);
      end
      3'd2: res = r1 & b;
      3'd3: res = r1 | b;
      3'd4: res = r1 ^ b;
      3'd5: res = r2;
      3'd6: res = r3;
      default: begin
        st  = sx(r1, w) + sx(r2, w) + (cin ? 68'sd1 : 68'sd0);
        sh  = sx(r1, h) + sx(r2, h) + (cin ? 68'sd1 : 68'sd0);
        uf  = ux(r1, w) + ux(r2, w) + (cin ? 68'd1 : 68'd0);
        uh  = ux(r1, h) + ux(r2, h) + (cin ? 68'd1 : 68'd0);
        res = uf[63:0];
        c   = uf >= (68'd1 << w);
        ch  = uh >= (68'd1 << h);
        v   = (st < lo) || (st > hi);
        vh  = (sh < loh) || (sh > hih);
      end
    endcase
    for (int i = w; i < 64; i++) res[i] = 1'b0;
    zh = 1'b1;
    for (int i = 0; i < h; i++) if (res[i]) zh = 1'b0;
    all0 = 1'b1; all1 = 1'b1;
    for (int i = vaw - 1; i < w; i++) if (res[i]) all0 = 1'b0; else all1 = 1'b0;
    m.res = res;
    m.tag = tg;
    m.ccf = {res[w-1], res == 64'd0, v, c};
    m.cch = {res[h-1], zh, vh, ch};
    m.va  = !(all0 || all1);
    return m;
  endfunction

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] msk, x;
    msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 5))
      0:       x = '0;
      1:       x = msk;
      2:       x = 64'd1 << (w - 1);
      3:       x = (64'd1 << (w - 1)) - 64'd1;
      default: x = {$urandom, $urandom} & msk;
    endcase
    return x;
  endfunction

  // One clock: log accepts into the expected queues and transfers into the
  // observed queues at the negedge, then return 1 time unit after the posedge.
  task automatic tick();
    rec_t r;
    @(negedge rclk);
    if (a_in_vld && a_in_rdy)
      exp_a.push_back(model(AW, AVA, a_op, a_inv, a_cin, a_rs1, a_rs2, a_rs3, a_tag));
    if (b_in_vld && b_in_rdy)
      exp_b.push_back(model(BW, BVA, b_op, b_inv, b_cin, {32'd0, b_rs1}, {32'd0, b_rs2},
                            {32'd0, b_rs3}, b_tag));
    if (a_out_vld && a_out_rdy) begin
      r.res = a_result; r.tag = a_out_tag; r.ccf = a_ccf; r.cch = a_cch; r.va = a_va;
      obs_a.push_back(r);
    end
    if (b_out_vld && b_out_rdy) begin
      r.res = {32'd0, b_result}; r.tag = b_out_tag; r.ccf = b_ccf; r.cch = b_cch; r.va = b_va;
      obs_b.push_back(r);
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic rand_a();
    a_op = 3'($urandom_range(0, 7)); a_inv = 1'($urandom); a_cin = 1'($urandom);
    a_rs1 = rnd(64); a_rs2 = rnd(64); a_rs3 = rnd(64);
  endtask

  task automatic rand_b();
    logic [63:0] t;
    b_op = 3'($urandom_range(0, 7)); b_inv = 1'($urandom); b_cin = 1'($urandom);
    t = rnd(32); b_rs1 = t[31:0];
    t = rnd(32); b_rs2 = t[31:0];
    t = rnd(32); b_rs3 = t[31:0];
    b_tag = 5'($urandom);
  endtask

  task automatic drain();
    a_in_vld = 0; b_in_vld = 0; a_out_rdy = 1; b_out_rdy = 1;
    repeat (6) tick();
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    checks++; if (a_out_vld !== 1'b0) begin errors++; $display("FAIL reset_a_out_vld: got %b want 0", a_out_vld); end
    checks++; if (a_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_a_in_rdy: got %b want 1", a_in_rdy); end
    checks++; if (b_out_vld !== 1'b0) begin errors++; $display("FAIL reset_b_out_vld: got %b want 0", b_out_vld); end
    checks++; if (b_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_b_in_rdy: got %b want 1", b_in_rdy); end
  endtask

  task automatic test_directed_a();
    a_out_rdy = 1; a_in_vld = 1; a_inv = 0; a_cin = 0; a_op = 3'd0; a_tag = 5'd1;
    a_rs1 = 64'hFFFF_FFFF_FFFF_FFFF; a_rs2 = 64'd1; a_rs3 = '0;
    tick();
    a_in_vld = 0;
    checks++; if (a_out_vld !== 1'b0) begin errors++; $display("FAIL add_latency1: out_vld got %b want 0", a_out_vld); end
    tick();
    checks++; if (a_out_vld !== 1'b1) begin errors++; $display("FAIL add_latency2: out_vld got %b want 1", a_out_vld); end
    checks++;
    if ({a_result, a_ccf, a_cch, a_va} !== {64'd0, 4'b0101, 4'b0101, 1'b0}) begin
      errors++;
      $display("FAIL add_wrap: got res=%h ccf=%b cch=%b va=%b want res=0 ccf=0101 cch=0101 va=0", a_result, a_ccf, a_cch, a_va);
    end
    a_in_vld = 1; a_op = 3'd1; a_tag = 5'd2; a_rs1 = 64'h7FFF_FFFF_FFFF_FFFF; a_rs2 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    a_op = 3'd4; a_inv = 1; a_tag = 5'd3; a_rs1 = 64'h1234; a_rs2 = 64'h1234;
    tick();
    checks++;
    if ({a_out_vld, a_result, a_ccf, a_cch, a_va} !== {1'b1, 64'h8000_0000_0000_0000, 4'b1011, 4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf: got vld=%b res=%h ccf=%b cch=%b va=%b want vld=1 res=8000000000000000 ccf=1011 cch=0100 va=1", a_out_vld, a_result, a_ccf, a_cch, a_va);
    end
    a_op = 3'd5; a_inv = 1; a_tag = 5'd4; a_rs2 = 64'd5;
    tick();
    checks++;
    if ({a_result, a_ccf, a_out_tag} !== {64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 5'd3}) begin
      errors++;
      $display("FAIL xnor: got res=%h ccf=%b tag=%0d want res=ffffffffffffffff ccf=1000 tag=3", a_result, a_ccf, a_out_tag);
    end
    a_in_vld = 0;
    tick();
    checks++;
    if ({a_result, a_ccf, a_out_tag} !== {64'd5, 4'b0000, 5'd4}) begin
      errors++;
      $display("FAIL move_inv: got res=%h ccf=%b tag=%0d want res=5 ccf=0000 tag=4", a_result, a_ccf, a_out_tag);
    end
    drain();
    exp_a.delete(); obs_a.delete();
  endtask

  task automatic test_backpressure();
    int sent, n0;
    logic [63:0] r0; logic [4:0] t0; logic [8:0] f0;
    rec_t o, e;
    sent = 0;
    a_out_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      a_in_vld = 1; a_tag = 5'(sent + 1); rand_a();
      n0 = exp_a.size();
      tick();
      if (exp_a.size() > n0) sent++;
    end
    checks++; if (sent !== AST) begin errors++; $display("FAIL bp_fill: accepted %0d want %0d", sent, AST); end
    checks++; if (a_in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy: got %b want 0", a_in_rdy); end
    checks++; if (a_out_tag !== 5'd1) begin errors++; $display("FAIL bp_head_tag: got %0d want 1", a_out_tag); end
    r0 = a_result; t0 = a_out_tag; f0 = {a_ccf, a_cch, a_va};
    tick(); tick();
    checks++;
    if ({a_out_vld, a_result, a_out_tag, a_ccf, a_cch, a_va} !== {1'b1, r0, t0, f0}) begin
      errors++;
      $display("FAIL bp_stable: got vld=%b res=%h tag=%0d want vld=1 res=%h tag=%0d", a_out_vld, a_result, a_out_tag, r0, t0);
    end
    a_out_rdy = 1;
    for (int i = 0; i < 20 && sent < 4; i++) begin
      a_tag = 5'(sent + 1); rand_a();
      n0 = exp_a.size();
      tick();
      if (exp_a.size() > n0) sent++;
    end
    drain();
    checks++;
    if (obs_a.size() !== 4 || exp_a.size() !== 4) begin
      errors++; $display("FAIL bp_count: observed %0d expected-queue %0d want 4", obs_a.size(), exp_a.size());
    end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      o = obs_a[i]; e = exp_a[i];
      checks++;
      if (o.tag !== 5'(i + 1) || {o.res, o.ccf, o.cch, o.va} !== {e.res, e.ccf, e.cch, e.va}) begin
        errors++;
        $display("FAIL bp_order[%0d]: got tag=%0d res=%h ccf=%b cch=%b va=%b want tag=%0d res=%h ccf=%b cch=%b va=%b",
                 i, o.tag, o.res, o.ccf, o.cch, o.va, i + 1, e.res, e.ccf, e.cch, e.va);
      end
    end
    exp_a.delete(); obs_a.delete();
  endtask

  task automatic test_reset_mid();
    rec_t o, e;
    a_out_rdy = 0;
    a_in_vld = 1; rand_a(); a_tag = 5'd7; tick();
    rand_a(); a_tag = 5'd8; tick();
    a_in_vld = 0;
    #2 arst_l = 0;
    #1;
    checks++; if (a_out_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_out_vld: got %b want 0", a_out_vld); end
    exp_a.delete(); obs_a.delete();
    @(posedge rclk); #1;
    arst_l = 1;
    #1;
    checks++; if (a_in_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_in_rdy: got %b want 1", a_in_rdy); end
    a_in_vld = 1; a_out_rdy = 1; rand_a(); a_tag = 5'd9;
    tick();
    drain();
    checks++;
    if (obs_a.size() !== 1 || exp_a.size() !== 1) begin
      errors++; $display("FAIL rst_mid_count: observed %0d expected-queue %0d want 1", obs_a.size(), exp_a.size());
    end else begin
      o = obs_a[0]; e = exp_a[0];
      checks++;
      if (o.tag !== 5'd9 || {o.res, o.ccf, o.cch, o.va} !== {e.res, e.ccf, e.cch, e.va}) begin
        errors++;
        $display("FAIL rst_mid_op: got tag=%0d res=%h want tag=9 res=%h", o.tag, o.res, e.res);
      end
    end
    exp_a.delete(); obs_a.delete();
  endtask

  task automatic test_w32();
    logic [31:0] t1 [4] = '{32'h0080_0000, 32'hFF80_0000, 32'h0000_FFFF, 32'h0000_7FFF};
    logic [31:0] t2 [4] = '{32'd0, 32'd0, 32'd1, 32'd1};
    logic [31:0] tr [4] = '{32'h0080_0000, 32'hFF80_0000, 32'h0001_0000, 32'h0000_8000};
    logic [3:0]  tf [4] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic [3:0]  th [4] = '{4'b0100, 4'b0100, 4'b0101, 4'b1010};
    logic        tv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    b_out_rdy = 1; b_inv = 0; b_cin = 0; b_op = 3'd0; b_rs3 = '0;
    for (int i = 0; i < 4; i++) begin
      b_in_vld = 1; b_rs1 = t1[i]; b_rs2 = t2[i]; b_tag = 5'(i + 1);
      tick();
      checks++;
      if ({b_out_vld, b_result, b_out_tag, b_ccf, b_cch, b_va} !== {1'b1, tr[i], 5'(i + 1), tf[i], th[i], tv[i]}) begin
        errors++;
        $display("FAIL w32_add[%0d]: got vld=%b res=%h tag=%0d ccf=%b cch=%b va=%b want vld=1 res=%h tag=%0d ccf=%b cch=%b va=%b",
                 i, b_out_vld, b_result, b_out_tag, b_ccf, b_cch, b_va, tr[i], i + 1, tf[i], th[i], tv[i]);
      end
    end
    drain();
    exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_random();
    rec_t o, e;
    for (int c = 0; c < 400; c++) begin
      a_in_vld = ($urandom_range(0, 3) != 0); a_out_rdy = ($urandom_range(0, 3) != 0);
      b_in_vld = ($urandom_range(0, 3) != 0); b_out_rdy = ($urandom_range(0, 3) != 0);
      rand_a(); a_tag = 5'($urandom); rand_b();
      tick();
    end
    drain();
    checks++;
    if (obs_a.size() !== exp_a.size() || obs_a.size() == 0) begin
      errors++; $display("FAIL rand_a_count: observed %0d expected %0d", obs_a.size(), exp_a.size());
    end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      o = obs_a[i]; e = exp_a[i];
      checks++;
      if ({o.res, o.tag, o.ccf, o.cch, o.va} !== {e.res, e.tag, e.ccf, e.cch, e.va}) begin
        errors++;
        $display("FAIL rand_a[%0d]: got res=%h tag=%0d ccf=%b cch=%b va=%b want res=%h tag=%0d ccf=%b cch=%b va=%b",
                 i, o.res, o.tag, o.ccf, o.cch, o.va, e.res, e.tag, e.ccf, e.cch, e.va);
      end
    end
    checks++;
    if (obs_b.size() !== exp_b.size() || obs_b.size() == 0) begin
      errors++; $display("FAIL rand_b_count: observed %0d expected %0d", obs_b.size(), exp_b.size());
    end
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
      o = obs_b[i]; e = exp_b[i];
      checks++;
      if ({o.res, o.tag, o.ccf, o.cch, o.va} !== {e.res, e.tag, e.ccf, e.cch, e.va}) begin
        errors++;
        $display("FAIL rand_b[%0d]: got res=%h tag=%0d ccf=%b cch=%b va=%b want res=%h tag=%0d ccf=%b cch=%b va=%b",
                 i, o.res, o.tag, o.ccf, o.cch, o.va, e.res, e.tag, e.ccf, e.cch, e.va);
      end
    end
    exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
  endtask

  initial begin
    arst_l = 1;
    a_in_vld = 0; a_out_rdy = 0; a_op = '0; a_inv = 0; a_cin = 0; a_rs1 = '0; a_rs2 = '0; a_rs3 = '0; a_tag = '0;
    b_in_vld = 0; b_out_rdy = 0; b_op = '0; b_inv = 0; b_cin = 0; b_rs1 = '0; b_rs2 = '0; b_rs3 = '0; b_tag = '0;
    #1 arst_l = 0;
    repeat (3) @(posedge rclk);
    #1 arst_l = 1;
    #1;
    test_reset();
    test_directed_a();
    test_backpressure();
    test_reset_mid();
    test_w32();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
